// File: rtl/mmult_seq_ctrl.sv
// Sequenced 3x3 matrix multiplier: one DATA_W x DATA_W multiplier and one accumulator
// are shared across 27 multiply-accumulate steps, visiting k fastest, then j, then i.
module mmult_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [0:9*DATA_W-1]   A_mat,
  input  logic [0:9*DATA_W-1]   B_mat,
  output logic                  busy,
  output logic                  valid,
  output logic                  overflow,
  output logic [0:9*ACC_W-1]    C_mat,
  output logic                  dbg_state
);

  // Handshake: start is accepted only in IDLE while abort is low; valid is a level that
  // rises with the last element write and falls only on reset, abort of a run, or the
  // next accepted start.
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = 2 * DATA_W + 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state;
  logic [DATA_W-1:0]     r_a [0:8];
  logic [DATA_W-1:0]     r_b [0:8];
  logic [1:0]            r_i;
  logic [1:0]            r_j;
  logic [1:0]            r_k;
  logic [ACC_W-1:0]      r_acc;
  logic                  r_busy;
  logic                  r_valid;
  logic                  r_ovf;
  logic [0:9*ACC_W-1]    r_c;

  logic [3:0]            w_a_idx;
  logic [3:0]            w_b_idx;
  logic [3:0]            w_c_idx;
  logic [PROD_W-1:0]     w_prod;
  logic [SUM_W-1:0]      w_sum;
  logic                  w_wrap;

  // Flat indices 3*row + col, built as 2*row + row + col.
  assign w_a_idx = {2'b00, r_i} + {1'b0, r_i, 1'b0} + {2'b00, r_k};
  assign w_b_idx = {2'b00, r_k} + {1'b0, r_k, 1'b0} + {2'b00, r_j};
  assign w_c_idx = {2'b00, r_i} + {1'b0, r_i, 1'b0} + {2'b00, r_j};

  assign w_prod = PROD_W'(r_a[w_a_idx]) * PROD_W'(r_b[w_b_idx]);
  assign w_sum  = ((r_k == 2'd0) ? '0 : SUM_W'(r_acc)) + SUM_W'(w_prod);
  assign w_wrap = |w_sum[SUM_W-1:ACC_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      for (int e = 0; e < 9; e++) begin
        r_a[e] <= '0;
        r_b[e] <= '0;
      end
      r_i     <= 2'd0;
      r_j     <= 2'd0;
      r_k     <= 2'd0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_c     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            for (int e = 0; e < 9; e++) begin
              r_a[e] <= A_mat[e*DATA_W +: DATA_W];
              r_b[e] <= B_mat[e*DATA_W +: DATA_W];
            end
            r_c     <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_i     <= 2'd0;
            r_j     <= 2'd0;
            r_k     <= 2'd0;
            r_acc   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end else begin
            r_acc <= w_sum[ACC_W-1:0];
            if (r_k == 2'd2) begin
              for (int e = 0; e < 9; e++) begin
                if (w_c_idx == 4'(e)) r_c[e*ACC_W +: ACC_W] <= w_sum[ACC_W-1:0];
              end
              if (w_wrap) r_ovf <= 1'b1;
              r_k <= 2'd0;
              if (r_j == 2'd2) begin
                r_j <= 2'd0;
                if (r_i == 2'd2) begin
                  r_i     <= 2'd0;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
                end else begin
                  r_i <= r_i + 2'd1;
                end
              end else begin
                r_j <= r_j + 2'd1;
              end
            end else begin
              r_k <= r_k + 2'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign overflow  = r_ovf;
  assign C_mat     = r_c;
  assign dbg_state = (r_state == S_RUN);

endmodule
